pipe_ctrl_unit: RTL and testbench

- Pipelined successor to the core's combinational control decoder.
- Decodes the ID-stage opcode into a control word and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Generates the load-use hazard stall itself instead of taking it as an input.
- Handles branch flush and a global memory freeze. Sits between the IF/ID register and the datapath stages of the 5-stage core.

---
 rtl/pipe_ctrl_pkg.sv | 73 +++++++
 rtl/pipe_ctrl_unit_decode.sv | 57 +++++
 rtl/pipe_ctrl_unit.sv | 123 ++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipelined control unit.
// Optional feature macro: PIPE_CTRL_JAL_EN (adds jal/jalr decode and a jump bit).
// Contents: opcode/ALU-op encodings, ID-stage control word, per-stage payloads.
package pipe_ctrl_pkg;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned OPC_W   = 7;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_IALU   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = ALUOP_W'(2'b10);

  // Decoded control word for the ID-stage instruction
  typedef struct packed {
    logic               alusrc;
    logic               memtoreg;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               branch;
`ifdef PIPE_CTRL_JAL_EN
    logic               jump;
`endif
    logic [ALUOP_W-1:0] aluop;
    logic               illegal;
    logic               uses_rs2;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // ID/EX payload: everything still needed from EX onwards
  typedef struct packed {
    logic               valid;
    logic               alusrc;
    logic               branch;
`ifdef PIPE_CTRL_JAL_EN
    logic               jump;
`endif
    logic [ALUOP_W-1:0] aluop;
    logic               illegal;
    logic               memread;
    logic               memwrite;
    logic               regwrite;
    logic               memtoreg;
    logic [REG_AW-1:0]  rd;
  } idex_t;

  // EX/MEM payload
  typedef struct packed {
    logic              memread;
    logic              memwrite;
    logic              regwrite;
    logic              memtoreg;
    logic [REG_AW-1:0] rd;
  } exmem_t;

  // MEM/WB payload
  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic [REG_AW-1:0] rd;
  } memwb_t;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// ctrl_decode: combinational opcode -> control word.
// Ports: opcode (in, OPC_W), ctrl (out, ctrl_t).
// Optional feature macro: PIPE_CTRL_JAL_EN (jal/jalr legal when defined).
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl
);

  // Unused fields stay 0; unknown opcodes only raise illegal
  always_comb begin
    ctrl = CTRL_BUBBLE;
    case (opcode)
      OPC_LOAD: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
      OPC_STORE: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.uses_rs2 = 1'b1;
      end
      OPC_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_FUNCT;
        ctrl.uses_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.aluop    = ALUOP_SUB;
        ctrl.uses_rs2 = 1'b1;
      end
      OPC_IALU: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
`ifdef PIPE_CTRL_JAL_EN
      OPC_JAL, OPC_JALR: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.jump     = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
`else
      OPC_JAL, OPC_JALR: ctrl.illegal = 1'b1;
`endif
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined control path for the 5-stage core.
// Decodes the ID opcode, carries control through ID/EX, EX/MEM, MEM/WB,
// and generates the load-use stall and IF/ID flush.
// Ports: clk, rst_n (sync, active-low); ID inputs id_valid/id_opcode/id_rs1/
// id_rs2/id_rd; branch_taken, ext_stall; outputs hazard_stall, ifid_flush
// (combinational) and registered ex_*/mem_*/wb_* controls and rd fields.
// Optional feature macro: PIPE_CTRL_JAL_EN (adds ex_jump output).
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [OPC_W-1:0]   id_opcode,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               branch_taken,
  input  logic               ext_stall,
  output logic               hazard_stall,
  output logic               ifid_flush,
  output logic               ex_valid,
  output logic               ex_alusrc,
  output logic               ex_branch,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_illegal,
`ifdef PIPE_CTRL_JAL_EN
  output logic               ex_jump,
`endif
  output logic               mem_memread,
  output logic               mem_memwrite,
  output logic               wb_regwrite,
  output logic               wb_memtoreg,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [REG_AW-1:0]  mem_rd,
  output logic [REG_AW-1:0]  wb_rd
);

  ctrl_t  id_ctrl;
  idex_t  idex_q, idex_d;
  exmem_t exmem_q;
  memwb_t memwb_q;
  logic   flush_c;
  logic   load_use_c;

  ctrl_decode u_decode (
    .opcode (id_opcode),
    .ctrl   (id_ctrl)
  );

  // Redirect from EX: a taken branch (or a jump when enabled)
`ifdef PIPE_CTRL_JAL_EN
  assign flush_c = branch_taken | idex_q.jump;
`else
  assign flush_c = branch_taken;
`endif

  // Load in EX whose nonzero rd feeds a source of the ID instruction
  assign load_use_c = id_valid & idex_q.valid & idex_q.memread
                    & (idex_q.rd != '0)
                    & ((idex_q.rd == id_rs1)
                       | (id_ctrl.uses_rs2 & (idex_q.rd == id_rs2)));

  // Flush dominates: the stalled instruction is being discarded anyway
  assign hazard_stall = load_use_c & ~flush_c;
  assign ifid_flush   = flush_c & ~ext_stall;

  // Next ID/EX content: decoded word or a bubble
  always_comb begin
    idex_d = '0;
    if (id_valid && !flush_c && !load_use_c) begin
      idex_d.valid    = 1'b1;
      idex_d.alusrc   = id_ctrl.alusrc;
      idex_d.branch   = id_ctrl.branch;
`ifdef PIPE_CTRL_JAL_EN
      idex_d.jump     = id_ctrl.jump;
`endif
      idex_d.aluop    = id_ctrl.aluop;
      idex_d.illegal  = id_ctrl.illegal;
      idex_d.memread  = id_ctrl.memread;
      idex_d.memwrite = id_ctrl.memwrite;
      idex_d.regwrite = id_ctrl.regwrite;
      idex_d.memtoreg = id_ctrl.memtoreg;
      idex_d.rd       = id_rd;
    end
  end

  // Stage registers: reset > freeze > advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else if (!ext_stall) begin
      idex_q           <= idex_d;
      exmem_q.memread  <= idex_q.memread;
      exmem_q.memwrite <= idex_q.memwrite;
      exmem_q.regwrite <= idex_q.regwrite;
      exmem_q.memtoreg <= idex_q.memtoreg;
      exmem_q.rd       <= idex_q.rd;
      memwb_q.regwrite <= exmem_q.regwrite;
      memwb_q.memtoreg <= exmem_q.memtoreg;
      memwb_q.rd       <= exmem_q.rd;
    end
  end

  assign ex_valid     = idex_q.valid;
  assign ex_alusrc    = idex_q.alusrc;
  assign ex_branch    = idex_q.branch;
  assign ex_aluop     = idex_q.aluop;
  assign ex_illegal   = idex_q.illegal;
`ifdef PIPE_CTRL_JAL_EN
  assign ex_jump      = idex_q.jump;
`endif
  assign ex_rd        = idex_q.rd;
  assign mem_memread  = exmem_q.memread;
  assign mem_memwrite = exmem_q.memwrite;
  assign mem_rd       = exmem_q.rd;
  assign wb_regwrite  = memwb_q.regwrite;
  assign wb_memtoreg  = memwb_q.memtoreg;
  assign wb_rd        = memwb_q.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Testbench for pipe_ctrl_unit: directed steps plus a random stream, checked
// against an instruction-level model of the pipeline.
module tb_pipe_ctrl_unit;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, id_valid, branch_taken, ext_stall;
  logic [OPC_W-1:0]   id_opcode;
  logic [REG_AW-1:0]  id_rs1, id_rs2, id_rd;
  logic               hazard_stall, ifid_flush;
  logic               ex_valid, ex_alusrc, ex_branch, ex_illegal;
  logic [ALUOP_W-1:0] ex_aluop;
  logic               mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg;
  logic [REG_AW-1:0]  ex_rd, mem_rd, wb_rd;
`ifdef PIPE_CTRL_JAL_EN
  logic               ex_jump;
`endif

  pipe_ctrl_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .branch_taken (branch_taken),
    .ext_stall    (ext_stall),
    .hazard_stall (hazard_stall),
    .ifid_flush   (ifid_flush),
    .ex_valid     (ex_valid),
    .ex_alusrc    (ex_alusrc),
    .ex_branch    (ex_branch),
    .ex_aluop     (ex_aluop),
    .ex_illegal   (ex_illegal),
`ifdef PIPE_CTRL_JAL_EN
    .ex_jump      (ex_jump),
`endif
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .wb_regwrite  (wb_regwrite),
    .wb_memtoreg  (wb_memtoreg),
    .ex_rd        (ex_rd),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd)
  );

  int checks = 0;
  int errors = 0;

  // Model: each stage holds an instruction (or nothing)
  typedef struct {
    bit       valid;
    bit [6:0] opc;
    bit [4:0] rd;
  } slot_t;

  slot_t m_ex, m_mem, m_wb;
  bit    known = 1'b0;
  bit    s_haz, s_flush;

  function automatic bit is_jump(bit [6:0] o);
`ifdef PIPE_CTRL_JAL_EN
    return (o == 7'b1101111) || (o == 7'b1100111);
`else
    return (o != o);
`endif
  endfunction
  function automatic bit is_load(bit [6:0] o);  return o == 7'b0000011; endfunction
  function automatic bit is_store(bit [6:0] o); return o == 7'b0100011; endfunction
  function automatic bit is_r(bit [6:0] o);     return o == 7'b0110011; endfunction
  function automatic bit is_beq(bit [6:0] o);   return o == 7'b1100011; endfunction
  function automatic bit is_ialu(bit [6:0] o);  return o == 7'b0010011; endfunction
  function automatic bit legal(bit [6:0] o);
    return is_load(o) || is_store(o) || is_r(o) || is_beq(o) || is_ialu(o) || is_jump(o);
  endfunction
  function automatic bit writes_reg(bit [6:0] o);
    return is_load(o) || is_r(o) || is_ialu(o) || is_jump(o);
  endfunction
  function automatic bit uses_imm(bit [6:0] o);
    return is_load(o) || is_store(o) || is_ialu(o) || is_jump(o);
  endfunction
  function automatic bit reads_rs2(bit [6:0] o);
    return is_r(o) || is_store(o) || is_beq(o);
  endfunction
  function automatic int alu_kind(bit [6:0] o);
    if (is_r(o)) return 2;
    if (is_beq(o)) return 1;
    return 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check ID-side combinational outputs, clock, check stage outputs
  task automatic cyc();
    bit    flush_m, haz_m;
    slot_t nx;
    #1;
    flush_m = branch_taken || (m_ex.valid && is_jump(m_ex.opc));
    haz_m = id_valid && m_ex.valid && is_load(m_ex.opc) && (m_ex.rd != 0) &&
            ((m_ex.rd == id_rs1) || (reads_rs2(id_opcode) && m_ex.rd == id_rs2)) &&
            !flush_m;
    s_haz   = haz_m;
    s_flush = flush_m && !ext_stall;
    if (known) begin
      chk("hazard_stall", 32'(hazard_stall), 32'(haz_m));
      chk("ifid_flush", 32'(ifid_flush), 32'(s_flush));
    end
    nx.valid = id_valid && !flush_m && !haz_m;
    nx.opc   = nx.valid ? id_opcode : 7'd0;
    nx.rd    = nx.valid ? id_rd : 5'd0;
    @(posedge clk);
    if (!rst_n) begin
      m_ex = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0};
      known = 1'b1;
    end else if (!ext_stall) begin
      m_wb = m_mem; m_mem = m_ex; m_ex = nx;
    end
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(m_ex.valid));
    chk("ex_alusrc", 32'(ex_alusrc), 32'(m_ex.valid && uses_imm(m_ex.opc)));
    chk("ex_branch", 32'(ex_branch), 32'(m_ex.valid && is_beq(m_ex.opc)));
    chk("ex_aluop", 32'(ex_aluop), m_ex.valid ? 32'(alu_kind(m_ex.opc)) : 32'd0);
    chk("ex_illegal", 32'(ex_illegal), 32'(m_ex.valid && !legal(m_ex.opc)));
`ifdef PIPE_CTRL_JAL_EN
    chk("ex_jump", 32'(ex_jump), 32'(m_ex.valid && is_jump(m_ex.opc)));
`endif
    chk("ex_rd", 32'(ex_rd), 32'(m_ex.rd));
    chk("mem_memread", 32'(mem_memread), 32'(m_mem.valid && is_load(m_mem.opc)));
    chk("mem_memwrite", 32'(mem_memwrite), 32'(m_mem.valid && is_store(m_mem.opc)));
    chk("mem_rd", 32'(mem_rd), 32'(m_mem.rd));
    chk("wb_regwrite", 32'(wb_regwrite), 32'(m_wb.valid && writes_reg(m_wb.opc)));
    chk("wb_memtoreg", 32'(wb_memtoreg), 32'(m_wb.valid && is_load(m_wb.opc)));
    chk("wb_rd", 32'(wb_rd), 32'(m_wb.rd));
  endtask

  task automatic drive(bit v, bit [6:0] opc, bit [4:0] rs1, bit [4:0] rs2,
                       bit [4:0] rd, bit bt, bit es);
    id_valid = v; id_opcode = opc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    branch_taken = bt; ext_stall = es;
    cyc();
  endtask

  localparam bit [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011;
  localparam bit [6:0] BQ = 7'b1100011, IA = 7'b0010011, BAD = 7'b1111111;

  bit [6:0] opc_pool [8];

  initial begin
    opc_pool = '{LD, ST, RT, BQ, IA, BAD, 7'b1101111, 7'b1100111};

    // Reset held two cycles with ext_stall and a valid R-type present
    rst_n = 1'b0;
    drive(1, RT, 5'd1, 5'd2, 5'd3, 0, 1);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    drive(1, RT, 5'd1, 5'd2, 5'd3, 0, 1);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    rst_n = 1'b1;

    // R-type, I-ALU, store stream
    drive(1, RT, 5'd1, 5'd2, 5'd3, 0, 0);
    chk("rt_aluop_c1", 32'(ex_aluop), 32'd2);
    drive(1, IA, 5'd1, 5'd0, 5'd4, 0, 0);
    drive(1, ST, 5'd6, 5'd7, 5'd0, 0, 0);
    chk("rt_wb_regwrite", 32'(wb_regwrite), 32'd1);
    chk("rt_wb_rd", 32'(wb_rd), 32'd3);
    drive(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    chk("st_mem_memwrite", 32'(mem_memwrite), 32'd1);
    drive(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    chk("st_wb_regwrite", 32'(wb_regwrite), 32'd0);

    // Load-use on rs2: one stall, one bubble, R-type enters EX late
    drive(1, LD, 5'd1, 5'd0, 5'd5, 0, 0);
    drive(1, RT, 5'd9, 5'd5, 5'd8, 0, 0);
    chk("lu_stall", 32'(s_haz), 32'd1);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    drive(1, RT, 5'd9, 5'd5, 5'd8, 0, 0);
    chk("lu_stall_gone", 32'(s_haz), 32'd0);
    chk("lu_late_ex_rd", 32'(ex_rd), 32'd8);

    // Load to x0 never stalls
    drive(1, LD, 5'd1, 5'd0, 5'd0, 0, 0);
    drive(1, RT, 5'd0, 5'd0, 5'd2, 0, 0);
    chk("x0_no_stall", 32'(s_haz), 32'd0);

    // Flush beats hazard
    drive(1, LD, 5'd1, 5'd0, 5'd6, 0, 0);
    drive(1, RT, 5'd6, 5'd6, 5'd2, 1, 0);
    chk("flush_seen", 32'(s_flush), 32'd1);
    chk("flush_bubble", 32'(ex_valid), 32'd0);

    // Freeze mid-stream, including a pending branch flush
    drive(1, BQ, 5'd1, 5'd2, 5'd0, 0, 0);
    drive(1, IA, 5'd3, 5'd0, 5'd9, 1, 1);
    chk("stall_no_flush", 32'(s_flush), 32'd0);
    drive(1, IA, 5'd3, 5'd0, 5'd9, 1, 1);
    drive(1, IA, 5'd3, 5'd0, 5'd9, 1, 1);
    drive(1, IA, 5'd3, 5'd0, 5'd9, 1, 0);
    chk("flush_after_stall", 32'(s_flush), 32'd1);

    // Illegal opcode
    drive(1, BAD, 5'd1, 5'd2, 5'd7, 0, 0);
    chk("illegal_ex", 32'(ex_illegal), 32'd1);
    drive(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    chk("illegal_no_wb", 32'(wb_regwrite), 32'd0);

    // Random stream
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive(bit'($urandom_range(0, 3) != 0),
            opc_pool[$urandom_range(0, 7)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            bit'($urandom_range(0, 7) == 0),
            bit'($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
